// File: rtl/add_sub_arb_pkg.sv
// add_sub_arb_pkg: shared FSM state type, default width, requester-id width and priority reset value
package add_sub_arb_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int N_DEF = 4;
    localparam int ID_W = 1;
    localparam logic PTR_RST = 1'b0;
endpackage

// File: rtl/add_sub.sv
// add_sub: N-bit adder/subtractor with carry-out and signed overflow
// Ports: A, B operands; Sel 0=add 1=subtract (A-B); S result; Co carry out of MSB; Ov signed overflow
module add_sub
    import add_sub_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Sel,
    output logic [N-1:0] S,
    output logic         Co,
    output logic         Ov
);
    // subtraction is A + ~B + 1, so the inverted B is also what the overflow sign test uses
    logic [N-1:0] bx;
    assign bx = B ^ {N{Sel}};
    assign {Co, S} = (N+1)'(A) + (N+1)'(bx) + (N+1)'(Sel);
    assign Ov = (A[N-1] == bx[N-1]) && (S[N-1] != A[N-1]);
endmodule

// File: rtl/add_sub_arb.sv
// add_sub_arb: two-requester round-robin front end sharing one add_sub unit
// Ports: clk, rst (sync, active high); req0/req1 valid, A, B, Sel in and ready out;
//        rsp_valid/rsp_ready handshake with rsp_S, rsp_Co, rsp_Ov, rsp_id; busy when not IDLE
module add_sub_arb
    import add_sub_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [N-1:0]    req0_A,
    input  logic [N-1:0]    req0_B,
    input  logic            req0_Sel,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [N-1:0]    req1_A,
    input  logic [N-1:0]    req1_B,
    input  logic            req1_Sel,
    output logic            req1_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N-1:0]    rsp_S,
    output logic            rsp_Co,
    output logic            rsp_Ov,
    output logic [ID_W-1:0] rsp_id,
    output logic            busy
);
    state_t state, state_nx;
    logic ptr;
    logic [N-1:0] a, b;
    logic sel;
    logic [ID_W-1:0] id;
    logic [N-1:0] s;
    logic co, ov, idle, gnt1;
    add_sub #(.N(N)) u_add_sub (.A(a), .B(b), .Sel(sel), .S(s), .Co(co), .Ov(ov));
    // ptr names the requester that wins when both are valid
    assign idle = (state == IDLE) && !rst;
    assign gnt1 = req1_valid && (!req0_valid || ptr);
    assign req0_ready = idle && req0_valid && !gnt1;
    assign req1_ready = idle && gnt1;
    assign rsp_valid = (state == DONE);
    assign busy = (state != IDLE);
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (req0_valid || req1_valid) ? CALC : IDLE;
            CALC:    state_nx = DONE;
            DONE:    state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= PTR_RST;
            a      <= '0;
            b      <= '0;
            sel    <= 1'b0;
            id     <= '0;
            rsp_S  <= '0;
            rsp_Co <= 1'b0;
            rsp_Ov <= 1'b0;
            rsp_id <= '0;
        end else begin
            state <= state_nx;
            if (req0_ready || req1_ready) begin
                a   <= req1_ready ? req1_A : req0_A;
                b   <= req1_ready ? req1_B : req0_B;
                sel <= req1_ready ? req1_Sel : req0_Sel;
                id  <= req1_ready;
            end
            if (state == CALC) begin
                rsp_S  <= s;
                rsp_Co <= co;
                rsp_Ov <= ov;
                rsp_id <= id;
            end
            // the requester just served loses priority to the other one
            if (state == DONE && rsp_ready) ptr <= ~id;
        end
    end
endmodule

// File: tb/tb_add_sub_arb.sv
// tb_add_sub_arb: randomized scoreboard bench for add_sub_arb against an arithmetic/round-robin model
module tb_add_sub_arb;
    typedef struct packed {
        logic [3:0] s;
        logic co;
        logic ov;
        logic id;
    } exp_t;
    logic clk = 1'b0;
    logic rst, rr;
    logic v0, v1, s0, s1;
    logic [3:0] a0, b0, a1, b1;
    logic rdy0, rdy1, rsp_valid, rsp_Co, rsp_Ov, busy;
    logic [3:0] rsp_S;
    logic [0:0] rsp_id;
    int checks = 0;
    int errors = 0;
    bit prio = 1'b0;
    bit rnd_rr = 1'b0;
    exp_t q[$];
    always #5 clk = ~clk;
    add_sub_arb #(.N(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_A(a0), .req0_B(b0), .req0_Sel(s0), .req0_ready(rdy0),
        .req1_valid(v1), .req1_A(a1), .req1_B(b1), .req1_Sel(s1), .req1_ready(rdy1),
        .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_S(rsp_S), .rsp_Co(rsp_Co),
        .rsp_Ov(rsp_Ov), .rsp_id(rsp_id), .busy(busy)
    );
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic exp_t model(input int a, input int b, input bit sel, input bit id);
        exp_t m;
        int r, sa, sb, sr;
        r  = sel ? a - b : a + b;
        sa = a >= 8 ? a - 16 : a;
        sb = b >= 8 ? b - 16 : b;
        sr = sel ? sa - sb : sa + sb;
        m.s  = 4'(r & 15);
        m.co = sel ? (a >= b) : (r > 15);
        m.ov = (sr > 7) || (sr < -8);
        m.id = id;
        return m;
    endfunction
    // waits for a grant, checks it against round-robin, queues the expected result, passes the accept edge
    task automatic wait_grant(output int g, output int w);
        bit e;
        g = -1;
        for (w = 0; w < 40; w++) begin
            @(negedge clk);
            if (rdy0 || rdy1) break;
        end
        if (w == 40) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        e = (v0 && v1) ? prio : v1;
        chk("grant", int'({rdy1, rdy0}), e ? 2 : 1);
        g = e;
        q.push_back(e ? model(a1, b1, s1, 1'b1) : model(a0, b0, s0, 1'b0));
        prio = ~e;
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input bit nv0, input logic [3:0] na0, input logic [3:0] nb0, input bit ns0,
                         input bit nv1, input logic [3:0] na1, input logic [3:0] nb1, input bit ns1,
                         output int w);
        int g;
        v0 = nv0; a0 = na0; b0 = nb0; s0 = ns0;
        v1 = nv1; a1 = na1; b1 = nb1; s1 = ns1;
        wait_grant(g, w);
        v0 = 1'b0;
        v1 = 1'b0;
    endtask
    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (q.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
                checks++;
                if ({rsp_S, rsp_Co, rsp_Ov, rsp_id} != q[0]) begin
                    errors++;
                    $display("FAIL rsp: got S=%h Co=%b Ov=%b id=%b expected S=%h Co=%b Ov=%b id=%b",
                             rsp_S, rsp_Co, rsp_Ov, rsp_id, q[0].s, q[0].co, q[0].ov, q[0].id);
                end
                if (rr) void'(q.pop_front());
            end
            chk("done_status", int'({busy, rdy0, rdy1}), 4);
        end
    end
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rr) rr = ($urandom_range(0, 3) != 0);
    end
    initial begin
        int g, w;
        rst = 1'b1; rr = 1'b1;
        v0 = 1'b1; v1 = 1'b1; a0 = 4'd0; b0 = 4'd0; s0 = 1'b0; a1 = 4'd0; b1 = 4'd0; s1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("ready_in_reset", int'({rdy0, rdy1}), 0);
        chk("reset_outputs", int'({rsp_valid, rsp_S, rsp_Co, rsp_Ov, rsp_id, busy}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, w);
        chk("first_grant_latency", w, 0);
        @(negedge clk);
        chk("valid_in_calc", int'(rsp_valid), 0);
        @(negedge clk);
        chk("valid_two_later", int'(rsp_valid), 1);
        @(posedge clk);
        #1;
        issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'b0011, 4'b0101, 1'b1, w);
        issue(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, w);
        drain();
        issue(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 4'd0, 4'd0, 1'b0, w);
        rst = 1'b1;
        q.delete();
        v0 = 1'b1; v1 = 1'b1;
        a0 = 4'($urandom); b0 = 4'($urandom); s0 = 1'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom); s1 = 1'($urandom);
        @(negedge clk);
        chk("ready_in_mid_reset", int'({rdy0, rdy1}), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_outputs", int'({rsp_valid, rsp_S, rsp_Co, rsp_Ov, rsp_id, busy}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prio = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, w);
            chk("rr_sequence", g, k % 2);
            chk("grant_spacing", w, k == 0 ? 0 : 2);
        end
        v0 = 1'b0; v1 = 1'b0;
        drain();
        rr = 1'b0;
        issue(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 4'd0, 4'd0, 1'b0, w);
        v0 = 1'b1;
        repeat (5) @(negedge clk);
        chk("held_in_done", int'(rsp_valid), 1);
        @(posedge clk);
        #1;
        rr = 1'b1;
        wait_grant(g, w);
        chk("exit_on_first_ready", w, 1);
        v0 = 1'b0;
        drain();
        rnd_rr = 1'b1;
        for (int i = 0; i < 512; i++) begin
            if (i % 2 == 0) issue(1'b1, 4'(i >> 5), 4'(i >> 1), 1'(i & 1), 1'b0, 4'd0, 4'd0, 1'b0, w);
            else issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'(i >> 5), 4'(i >> 1), 1'(i & 1), w);
        end
        for (int i = 0; i < 200; i++) begin
            bit r0, r1;
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            issue(r0, 4'($urandom), 4'($urandom), 1'($urandom), r1, 4'($urandom), 4'($urandom), 1'($urandom), w);
        end
        rnd_rr = 1'b0;
        @(posedge clk);
        #1;
        rr = 1'b1;
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
